// File: rtl/cordic_pair_collector.sv
// cordic_pair_collector: re-pairs serial CORDIC results into {one, two, sum} records
// and buffers them in a 2-entry FIFO with a valid/ack output handshake.
module cordic_pair_collector #(
   parameter int CORDIC_DATA_WIDTH = 22,
   parameter int FLOAT_DATA_WIDTH  = 32,
   parameter int FIFO_DEPTH        = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clk_en,
   input  logic [CORDIC_DATA_WIDTH-1:0] result_in,
   input  logic [FLOAT_DATA_WIDTH-1:0]  squared_in,
   input  logic                         valid_in,
   input  logic                         pipeline_cleared_in,
   input  logic                         clear_flags,
   input  logic                         out_ack,
   output logic [CORDIC_DATA_WIDTH-1:0] res_one,
   output logic [CORDIC_DATA_WIDTH-1:0] res_two,
   output logic [FLOAT_DATA_WIDTH-1:0]  sq_one,
   output logic [FLOAT_DATA_WIDTH-1:0]  sq_two,
   output logic [CORDIC_DATA_WIDTH:0]   res_sum,
   output logic                         out_valid,
   output logic                         idle,
   output logic                         pair_error,
   output logic                         overflow
);
   localparam int CW = CORDIC_DATA_WIDTH;
   localparam int FW = FLOAT_DATA_WIDTH;
   localparam logic [1:0] FULL = 2'(FIFO_DEPTH);

   typedef enum logic {FIRST, SECOND} state_t;

   typedef struct packed {
      logic [CW:0]   sum;
      logic [CW-1:0] r1;
      logic [CW-1:0] r2;
      logic [FW-1:0] s1;
      logic [FW-1:0] s2;
   } rec_t;

   state_t        state, state_n;
   logic [CW-1:0] one_res;
   logic [FW-1:0] one_sq;
   rec_t          mem [2];
   logic          wr_ptr, rd_ptr;
   logic [1:0]    count;
   logic          pc_hold, pc_eff;
   logic          push, pop, wr, err_set, ovf_set;

   always_comb begin
      state_n = state;
      push    = 1'b0;
      err_set = 1'b0;
      if (state == FIRST)
         state_n = (clk_en & valid_in) ? SECOND : FIRST;
      else begin
         state_n = clk_en ? FIRST : SECOND;
         push    = clk_en & valid_in;
         err_set = clk_en & ~valid_in;
      end
   end

   assign out_valid = (count != 2'd0);
   assign pop       = out_valid & out_ack;
   // A full FIFO still accepts a pair if the head leaves on the same edge.
   assign wr        = push & ((count != FULL) | pop);
   assign ovf_set   = push & (count == FULL) & ~pop;
   assign pc_eff    = clk_en ? pipeline_cleared_in : pc_hold;

   assign res_one = mem[rd_ptr].r1;
   assign res_two = mem[rd_ptr].r2;
   assign sq_one  = mem[rd_ptr].s1;
   assign sq_two  = mem[rd_ptr].s2;
   assign res_sum = mem[rd_ptr].sum;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= FIRST;
         one_res    <= '0;
         one_sq     <= '0;
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         count      <= 2'd0;
         pc_hold    <= 1'b0;
         idle       <= 1'b0;
         pair_error <= 1'b0;
         overflow   <= 1'b0;
         for (int i = 0; i < 2; i++) mem[i] <= '0;
      end else begin
         state <= state_n;
         if (state == FIRST && clk_en && valid_in) begin
            one_res <= result_in;
            one_sq  <= squared_in;
         end
         if (wr) begin
            mem[wr_ptr] <= {{1'b0, one_res} + {1'b0, result_in}, one_res, result_in, one_sq, squared_in};
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count      <= count + {1'b0, wr} - {1'b0, pop};
         pc_hold    <= pc_eff;
         idle       <= (state == FIRST) & (count == 2'd0) & pc_eff;
         pair_error <= err_set | (pair_error & ~clear_flags);
         overflow   <= ovf_set | (overflow & ~clear_flags);
      end
   end
endmodule

// File: tb/tb_cordic_pair_collector.sv
// tb_cordic_pair_collector: directed vectors with hand-computed expectations.
module tb_cordic_pair_collector;
   logic        clk = 1'b0, rst = 1'b0, clk_en = 1'b0, valid_in = 1'b0;
   logic        pipeline_cleared_in = 1'b0, clear_flags = 1'b0, out_ack = 1'b0;
   logic [21:0] result_in = '0;
   logic [31:0] squared_in = '0;
   logic [21:0] res_one, res_two;
   logic [31:0] sq_one, sq_two;
   logic [22:0] res_sum;
   logic        out_valid, idle, pair_error, overflow;
   int          total = 0, bad = 0;

   cordic_pair_collector dut (
      .clk(clk), .rst(rst), .clk_en(clk_en), .result_in(result_in),
      .squared_in(squared_in), .valid_in(valid_in),
      .pipeline_cleared_in(pipeline_cleared_in), .clear_flags(clear_flags),
      .out_ack(out_ack), .res_one(res_one), .res_two(res_two), .sq_one(sq_one),
      .sq_two(sq_two), .res_sum(res_sum), .out_valid(out_valid), .idle(idle),
      .pair_error(pair_error), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [21:0] r, input logic [31:0] s);
      clk_en = 1'b1; valid_in = 1'b1; result_in = r; squared_in = s;
      step();
      valid_in = 1'b0;
   endtask

   task automatic pop_one();
      out_ack = 1'b1;
      step();
      out_ack = 1'b0;
   endtask

   initial begin
      #3;
      chk("rst_valid", 64'(out_valid), 64'h0);
      chk("rst_sum", 64'(res_sum), 64'h0);
      chk("rst_idle", 64'(idle), 64'h0);
      chk("rst_flags", 64'({pair_error, overflow}), 64'h0);
      step();
      rst = 1'b1;
      clk_en = 1'b1;
      step();
      send(22'h00010, 32'h3F800000);
      send(22'h00020, 32'h40000000);
      chk("p1_valid", 64'(out_valid), 64'h1);
      chk("p1_res_one", 64'(res_one), 64'h10);
      chk("p1_res_two", 64'(res_two), 64'h20);
      chk("p1_sum", 64'(res_sum), 64'h30);
      chk("p1_sq_one", 64'(sq_one), 64'h3F800000);
      chk("p1_sq_two", 64'(sq_two), 64'h40000000);
      pop_one();
      chk("p1_popped", 64'(out_valid), 64'h0);
      send(22'h3FFFFF, 32'h0);
      send(22'h000001, 32'h0);
      chk("carry_sum", 64'(res_sum), 64'h400000);
      pop_one();
      send(22'h5, 32'h55);
      clk_en = 1'b0;
      repeat (3) step();
      send(22'h6, 32'h66);
      chk("stall_one", 64'(res_one), 64'h5);
      chk("stall_two", 64'(res_two), 64'h6);
      chk("stall_sq_two", 64'(sq_two), 64'h66);
      chk("stall_noerr", 64'(pair_error), 64'h0);
      pop_one();
      send(22'h7, 32'h77);
      step();
      chk("perr_set", 64'(pair_error), 64'h1);
      chk("perr_nopush", 64'(out_valid), 64'h0);
      send(22'h8, 32'h88);
      send(22'h9, 32'h99);
      chk("perr_one", 64'(res_one), 64'h8);
      chk("perr_two", 64'(res_two), 64'h9);
      pop_one();
      clear_flags = 1'b1;
      step();
      clear_flags = 1'b0;
      chk("perr_clr", 64'(pair_error), 64'h0);
      send(22'h1, 32'h11); send(22'h2, 32'h22);
      send(22'h3, 32'h33); send(22'h4, 32'h44);
      send(22'h5, 32'h55); send(22'h6, 32'h66);
      chk("ovf_set", 64'(overflow), 64'h1);
      chk("ovf_head", 64'({res_one, res_two}), 64'({22'h1, 22'h2}));
      pop_one();
      chk("ovf_second", 64'({res_one, res_two}), 64'({22'h3, 22'h4}));
      pop_one();
      chk("ovf_dropped", 64'(out_valid), 64'h0);
      clear_flags = 1'b1;
      step();
      clear_flags = 1'b0;
      chk("ovf_clr", 64'(overflow), 64'h0);
      send(22'hA, 32'h0); send(22'hB, 32'h0);
      send(22'hC, 32'h0); send(22'hD, 32'h0);
      send(22'hE, 32'h0);
      out_ack = 1'b1;
      send(22'hF, 32'h0);
      out_ack = 1'b0;
      chk("pushpop_noovf", 64'(overflow), 64'h0);
      chk("pushpop_head", 64'({res_one, res_two}), 64'({22'hC, 22'hD}));
      pop_one();
      chk("pushpop_new", 64'({res_one, res_two, res_sum}), 64'({22'hE, 22'hF, 23'h1D}));
      pop_one();
      chk("pushpop_empty", 64'(out_valid), 64'h0);
      send(22'h11, 32'h1); send(22'h12, 32'h2);
      send(22'h13, 32'h3);
      rst = 1'b0;
      #2;
      chk("arst_valid", 64'(out_valid), 64'h0);
      chk("arst_data", 64'({res_one, res_two, res_sum}), 64'h0);
      chk("arst_sq", 64'({sq_one, sq_two}), 64'h0);
      step();
      rst = 1'b1;
      step();
      send(22'h21, 32'h1); send(22'h22, 32'h2);
      chk("arst_fresh", 64'({res_one, res_two}), 64'({22'h21, 22'h22}));
      chk("arst_noerr", 64'(pair_error), 64'h0);
      pipeline_cleared_in = 1'b1;
      pop_one();
      step();
      chk("idle_set", 64'(idle), 64'h1);
      send(22'h30, 32'h0);
      clk_en = 1'b0;
      step();
      chk("idle_drop", 64'(idle), 64'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
